// File: rtl/tl_insn_responder_if.sv
// TileLink-UL A/D channel bundle for the instruction fetch port.
// The fetch unit takes the master modport and the responder takes the slave modport.
interface tl_insn_responder_if;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic        a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;

    logic        d_valid;
    logic        d_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic        d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready
    );
endinterface

// File: rtl/tl_insn_responder.sv
// TileLink-UL read-only responder for instruction fetch: SRAM read stage plus in-order response queue.
// Optional per-byte SRAM parity checking is enabled by defining TL_INSN_RESP_PARITY_EN.
module tl_insn_responder #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 3,
    localparam int         AW         = $clog2(MEM_WORDS)
) (
    input  logic          clock,
    input  logic          reset_n,
    tl_insn_responder_if.slave tl,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic [31:0]   mem_rdata
`ifdef TL_INSN_RESP_PARITY_EN
    ,
    input  logic [3:0]    mem_rparity
`endif
);

    localparam int          PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW        = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [32:0] WIN_BYTES = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        KIND_GET_OK,
        KIND_GET_BAD,
        KIND_PUT,
        KIND_HINT
    } kind_e;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic        source;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } entry_t;

    logic [31:0]   w_offset;
    logic          w_in_range;
    logic          w_aligned;
    kind_e         w_kind;
    logic          w_a_ready;
    logic          w_accept;
    logic [CW-1:0] w_occ;
    logic          w_parity_err;
    entry_t        w_push_entry;
    entry_t        w_head;
    logic          w_d_valid;
    logic          w_push;
    logic          w_pop;
    logic          w_unused;

    logic          r_s1_valid;
    kind_e         r_s1_kind;
    logic [3:0]    r_s1_size;
    logic          r_s1_source;

    entry_t        r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    // Parameter, mask, write data and corrupt carry nothing for a read-only port.
    assign w_unused = ^{tl.a_param, tl.a_mask, tl.a_data, tl.a_corrupt};

    // Addresses below the base wrap to a large offset, so one unsigned compare covers both bounds.
    assign w_offset   = tl.a_address - BASE_ADDR;
    assign w_in_range = {1'b0, w_offset} < WIN_BYTES;

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        w_aligned = 1'b0;
        case (tl.a_size)
            4'd0:    w_aligned = 1'b1;
            4'd1:    w_aligned = ~tl.a_address[0];
            4'd2:    w_aligned = (tl.a_address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
    end

    always_comb begin
        w_kind = KIND_GET_BAD;
        case (tl.a_opcode)
            3'd0, 3'd1: w_kind = KIND_PUT;
            3'd4:       w_kind = (w_in_range && w_aligned) ? KIND_GET_OK : KIND_GET_BAD;
            3'd5:       w_kind = KIND_HINT;
            default:    w_kind = KIND_GET_BAD;
        endcase
    end

    // Space is judged on registered state only, keeping d_ready out of the a_ready path.
    assign w_occ     = r_count + CW'(r_s1_valid);
    assign w_a_ready = reset_n & (w_occ < CW'(FIFO_DEPTH));
    assign w_accept  = tl.a_valid & w_a_ready;
    assign tl.a_ready = w_a_ready;

    assign mem_req  = w_accept & (w_kind == KIND_GET_OK);
    assign mem_addr = mem_req ? w_offset[AW+1:2] : '0;

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_kind   <= KIND_GET_BAD;
            r_s1_size   <= '0;
            r_s1_source <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_kind   <= w_kind;
                r_s1_size   <= tl.a_size;
                r_s1_source <= tl.a_source;
            end
        end
    end

`ifdef TL_INSN_RESP_PARITY_EN
    always_comb begin
        w_parity_err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if ((^mem_rdata[8*i +: 8]) != mem_rparity[i]) begin
                w_parity_err = 1'b1;
            end
        end
    end
`else
    assign w_parity_err = 1'b0;
`endif

    always_comb begin
        w_push_entry        = '0;
        w_push_entry.size   = r_s1_size;
        w_push_entry.source = r_s1_source;
        case (r_s1_kind)
            KIND_GET_OK: begin
                w_push_entry.opcode  = 3'd1;
                w_push_entry.data    = mem_rdata;
                w_push_entry.corrupt = w_parity_err;
            end
            KIND_GET_BAD: begin
                w_push_entry.opcode  = 3'd1;
                w_push_entry.denied  = 1'b1;
                w_push_entry.corrupt = 1'b1;
            end
            KIND_PUT: begin
                w_push_entry.opcode = 3'd0;
                w_push_entry.denied = 1'b1;
            end
            default: begin
                w_push_entry.opcode = 3'd2;
            end
        endcase
    end

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_d_valid = (r_count != '0);
    assign w_push    = r_s1_valid;
    assign w_pop     = w_d_valid & tl.d_ready;
    assign w_head    = r_fifo[r_head];

    // NOTE: queue storage has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_tail] <= w_push_entry;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= ptr_next(r_tail);
            if (w_pop)  r_head <= ptr_next(r_head);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Fields read as zero whenever the queue is empty, including throughout reset.
    assign tl.d_valid   = w_d_valid;
    assign tl.d_opcode  = w_d_valid ? w_head.opcode  : '0;
    assign tl.d_size    = w_d_valid ? w_head.size    : '0;
    assign tl.d_source  = w_d_valid ? w_head.source  : 1'b0;
    assign tl.d_denied  = w_d_valid ? w_head.denied  : 1'b0;
    assign tl.d_corrupt = w_d_valid ? w_head.corrupt : 1'b0;
    assign tl.d_data    = w_d_valid ? w_head.data    : '0;
    assign tl.d_param   = '0;
    assign tl.d_sink    = 1'b0;

endmodule

// File: tb/tb_tl_insn_responder.sv
// Directed self-checking bench for tl_insn_responder with a synchronous-read SRAM model.
// Response contents are checked in order against a queue of hand-computed expectations.
module tb_tl_insn_responder;

    localparam int AW = 10;
`ifdef TL_INSN_RESP_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  size;
        logic        src;
        logic        den;
        logic        cor;
        logic [31:0] data;
    } rsp_t;

    logic          clock;
    logic          reset_n;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic [31:0]   sram [1024];
`ifdef TL_INSN_RESP_PARITY_EN
    logic [3:0]    mem_rparity;
    logic          parity_flip;
`endif

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    rsp_t exp_q[$];
    int   pop_cyc[$];

    tl_insn_responder_if tl_bus ();

    tl_insn_responder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .tl        (tl_bus),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
`ifdef TL_INSN_RESP_PARITY_EN
        ,
        .mem_rparity (mem_rparity)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // SRAM model: data appears the cycle after the request.
    always @(posedge clock) begin
        if (mem_req) begin
            mem_rdata <= sram[mem_addr];
`ifdef TL_INSN_RESP_PARITY_EN
            for (int i = 0; i < 4; i++) begin
                mem_rparity[i] <= (^sram[mem_addr][8*i +: 8]) ^ (i == 0 ? parity_flip : 1'b0);
            end
`endif
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every completed D beat is compared with the oldest outstanding expectation.
    always @(negedge clock) begin
        rsp_t e;
        if (tl_bus.d_valid && tl_bus.d_ready) begin
            pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("d_rsp",
                      {tl_bus.d_opcode, tl_bus.d_size, tl_bus.d_source, tl_bus.d_denied,
                       tl_bus.d_corrupt, tl_bus.d_data, tl_bus.d_param, tl_bus.d_sink},
                      {e.op, e.size, e.src, e.den, e.cor, e.data, 2'b00, 1'b0});
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [3:0] size,
                         input logic src, input logic exp_req, input logic [AW-1:0] exp_maddr,
                         input logic [2:0] eop, input logic eden, input logic ecor,
                         input logic [31:0] edata, output int waits);
        rsp_t e;
        tl_bus.a_opcode  = op;
        tl_bus.a_address = addr;
        tl_bus.a_size    = size;
        tl_bus.a_source  = src;
        tl_bus.a_valid   = 1'b1;
        #1;
        waits = 0;
        while (!tl_bus.a_ready && waits < 50) begin
            tick();
            waits++;
        end
        if (!tl_bus.a_ready) begin
            check("a_ready_timeout", 64'd0, 64'd1);
            tl_bus.a_valid = 1'b0;
            return;
        end
        check("mem_req", mem_req, exp_req);
        if (exp_req) check("mem_addr", mem_addr, exp_maddr);
        e = '{op: eop, size: size, src: src, den: eden, cor: ecor, data: edata};
        exp_q.push_back(e);
        tick();
        tl_bus.a_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w;
        int acc;
        int total_waits;
        int dv_seen;

        for (int i = 0; i < 1024; i++) sram[i] = 32'hC0DE_0000 | i;
        sram[4] = 32'hDEAD_BEEF;
`ifdef TL_INSN_RESP_PARITY_EN
        parity_flip = 1'b0;
`endif
        mem_rdata        = '0;
        reset_n          = 1'b0;
        tl_bus.a_valid   = 1'b1;
        tl_bus.a_opcode  = 3'd4;
        tl_bus.a_param   = '0;
        tl_bus.a_size    = 4'd2;
        tl_bus.a_source  = 1'b0;
        tl_bus.a_address = 32'h0;
        tl_bus.a_mask    = 4'hF;
        tl_bus.a_data    = '0;
        tl_bus.a_corrupt = 1'b0;
        tl_bus.d_ready   = 1'b0;

        // Reset state, with a legal request pending to show nothing is accepted.
        repeat (3) tick();
        check("rst_a_ready", tl_bus.a_ready, 0);
        check("rst_d_valid", tl_bus.d_valid, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_d_fields", {tl_bus.d_opcode, tl_bus.d_size, tl_bus.d_source, tl_bus.d_denied,
                               tl_bus.d_corrupt, tl_bus.d_data}, 0);
        tl_bus.a_valid = 1'b0;
        reset_n        = 1'b1;
        #1;
        check("a_ready_after_release", tl_bus.a_ready, 1);
        tl_bus.d_ready = 1'b1;

        // Single Get with two-cycle latency.
        issue(3'd4, 32'h10, 4'd2, 1'b1, 1'b1, 10'd4, 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, w);
        check("lat_n1_d_valid", tl_bus.d_valid, 0);
        tick();
        check("lat_n2_d_valid", tl_bus.d_valid, 1);
        check("lat_n2_d_data", tl_bus.d_data, 32'hDEAD_BEEF);
        drain();

        // Back-to-back Gets.
        pop_cyc.delete();
        total_waits = 0;
        for (int i = 0; i < 8; i++) begin
            issue(3'd4, 32'(4 * (16 + i)), 4'd2, 1'(i), 1'b1, 10'(16 + i),
                  3'd1, 1'b0, 1'b0, 32'hC0DE_0000 | (16 + i), w);
            total_waits += w;
        end
        drain();
        check("b2b_a_ready_waits", total_waits, 0);
        check("b2b_pop_count", pop_cyc.size(), 8);
        if (pop_cyc.size() == 8) check("b2b_consecutive", pop_cyc[7] - pop_cyc[0], 7);

        // Backpressure: queue fills at three, head holds steady.
        tl_bus.d_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            tl_bus.a_opcode  = 3'd4;
            tl_bus.a_address = 32'(4 * (8 + acc));
            tl_bus.a_size    = 4'd2;
            tl_bus.a_source  = 1'(acc);
            tl_bus.a_valid   = 1'b1;
            #1;
            if (tl_bus.a_ready) begin
                exp_q.push_back('{op: 3'd1, size: 4'd2, src: 1'(acc), den: 1'b0, cor: 1'b0,
                                  data: 32'hC0DE_0000 | (8 + acc)});
                acc++;
            end
            tick();
        end
        tl_bus.a_valid = 1'b0;
        #1;
        check("bp_accepted", acc, 3);
        check("bp_a_ready_full", tl_bus.a_ready, 0);
        check("bp_d_valid", tl_bus.d_valid, 1);
        check("bp_head_data", tl_bus.d_data, 32'hC0DE_0008);
        tick();
        check("bp_hold_data", tl_bus.d_data, 32'hC0DE_0008);
        check("bp_hold_source", tl_bus.d_source, 0);
        tl_bus.d_ready = 1'b1;
        #1;
        check("bp_a_ready_pop_cycle", tl_bus.a_ready, 0);
        tick();
        check("bp_a_ready_after_pop", tl_bus.a_ready, 1);
        drain();

        // Illegal Gets and other denied opcodes.
        issue(3'd4, 32'h1002, 4'd2, 1'b0, 1'b0, 10'd0, 3'd1, 1'b1, 1'b1, 32'h0, w);
        issue(3'd4, 32'h1000, 4'd2, 1'b1, 1'b0, 10'd0, 3'd1, 1'b1, 1'b1, 32'h0, w);
        issue(3'd4, 32'h0012, 4'd2, 1'b0, 1'b0, 10'd0, 3'd1, 1'b1, 1'b1, 32'h0, w);
        issue(3'd4, 32'h0000, 4'd3, 1'b0, 1'b0, 10'd0, 3'd1, 1'b1, 1'b1, 32'h0, w);
        issue(3'd2, 32'h0000, 4'd2, 1'b1, 1'b0, 10'd0, 3'd1, 1'b1, 1'b1, 32'h0, w);
        issue(3'd7, 32'h0000, 4'd2, 1'b0, 1'b0, 10'd0, 3'd1, 1'b1, 1'b1, 32'h0, w);
        // Edge-of-window and halfword Gets stay legal.
        issue(3'd4, 32'h0FFC, 4'd2, 1'b1, 1'b1, 10'd1023, 3'd1, 1'b0, 1'b0, 32'hC0DE_03FF, w);
        issue(3'd4, 32'h0002, 4'd1, 1'b0, 1'b1, 10'd0, 3'd1, 1'b0, 1'b0, 32'hC0DE_0000, w);
        // Put and Intent.
        issue(3'd0, 32'h0020, 4'd2, 1'b1, 1'b0, 10'd0, 3'd0, 1'b1, 1'b0, 32'h0, w);
        issue(3'd1, 32'h0024, 4'd1, 1'b0, 1'b0, 10'd0, 3'd0, 1'b1, 1'b0, 32'h0, w);
        issue(3'd5, 32'h0028, 4'd2, 1'b1, 1'b0, 10'd0, 3'd2, 1'b0, 1'b0, 32'h0, w);
        drain();

        // Parity error on a legal Get flags corrupt only when checking is built in.
`ifdef TL_INSN_RESP_PARITY_EN
        parity_flip = 1'b1;
`endif
        issue(3'd4, 32'h0030, 4'd2, 1'b0, 1'b1, 10'd12, 3'd1, 1'b0, PAR_EN, 32'hC0DE_000C, w);
        drain();
`ifdef TL_INSN_RESP_PARITY_EN
        parity_flip = 1'b0;
`endif

        // Reset with two queued responses discards them.
        tl_bus.d_ready = 1'b0;
        issue(3'd4, 32'h0040, 4'd2, 1'b0, 1'b1, 10'd16, 3'd1, 1'b0, 1'b0, 32'hC0DE_0010, w);
        issue(3'd4, 32'h0044, 4'd2, 1'b1, 1'b1, 10'd17, 3'd1, 1'b0, 1'b0, 32'hC0DE_0011, w);
        tick();
        tick();
        check("mid_rst_queued_valid", tl_bus.d_valid, 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_a_ready", tl_bus.a_ready, 0);
        tick();
        check("mid_rst_d_valid", tl_bus.d_valid, 0);
        check("mid_rst_d_data", tl_bus.d_data, 0);
        exp_q.delete();
        reset_n        = 1'b1;
        tl_bus.d_ready = 1'b1;
        #1;
        check("mid_rst_a_ready_release", tl_bus.a_ready, 1);
        dv_seen = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (tl_bus.d_valid) dv_seen++;
        end
        check("mid_rst_no_stale", dv_seen, 0);
        issue(3'd4, 32'h0004, 4'd2, 1'b1, 1'b1, 10'd1, 3'd1, 1'b0, 1'b0, 32'hC0DE_0001, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_insn_responder.md
# tl_insn_responder

TileLink-UL responder for the hart's instruction fetch port. It accepts A-channel requests from the fetch unit, reads a word from an external synchronous-read instruction SRAM, and returns D-channel responses in order through a small credit-limited response queue. It sits between the hart's instruction TL master and the instruction SRAM macro. It is the slave end of the instruction D-channel bundle.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0000: byte base address of the memory window.
- `MEM_WORDS`, default 1024: window size in 32-bit words, a power of 2. `AW = $clog2(MEM_WORDS)`.
- `FIFO_DEPTH`, default 3: response queue depth, minimum 2.

Ports (one clock, `clock`; synchronous active-low reset, `reset_n`):
- `clock` in 1: clock.
- `reset_n` in 1: synchronous, active-low reset.
- `a_valid` in 1, `a_ready` out 1: A-channel handshake.
- `a_opcode` in 3, `a_param` in 3, `a_size` in 4, `a_source` in 1, `a_address` in 32, `a_mask` in 4, `a_data` in 32, `a_corrupt` in 1: A-channel fields.
- `d_valid` out 1, `d_ready` in 1: D-channel handshake.
- `d_opcode` out 3, `d_param` out 2, `d_size` out 4, `d_source` out 1, `d_sink` out 1, `d_denied` out 1, `d_data` out 32, `d_corrupt` out 1: D-channel fields.
- `mem_req` out 1, `mem_addr` out AW: SRAM read request. The word address is `(a_address-BASE_ADDR)>>2`.
- `mem_rdata` in 32: SRAM read data, valid one cycle after `mem_req`.
- `mem_rparity` in 4: per-byte even parity. Present only with `TL_INSN_RESP_PARITY_EN`.

## Operation
- Accept: an A request is accepted on `a_valid & a_ready`.
  - `a_ready = reset_n & (occ < FIFO_DEPTH)`.
  - `occ = fifo_count + s1_valid`.
  - There is no combinational path from `d_ready` to `a_ready`.
- Classification at accept:
  - Get (4) is legal when all three hold: the address is inside `[BASE_ADDR, BASE_ADDR+4*MEM_WORDS)`, `a_size<=2`, and `a_address[a_size-1:0]==0`.
  - Legal Get: `mem_req=1` in the accept cycle. Response is AccessAckData (1) with `d_data=mem_rdata` and `denied=0`.
  - Illegal Get, Arithmetic (2) or Logical (3): no `mem_req`. Response is AccessAckData (1) with `denied=1`, `corrupt=1`, `data=0`.
  - PutFull (0) or PutPartial (1): the port is read-only. Response is AccessAck (0) with `denied=1`, `corrupt=0`, `data=0`.
  - Intent (5): response is HintAck (2) with `denied=0`.
  - Opcodes 6 and 7: handled as Get-illegal.
- Stage s1 holds the opcode class, `size` and `source` for the cycle after accept. At the end of that cycle, s1 pushes `{opcode, size, source, denied, corrupt, data}` into the FIFO. `data` is captured from `mem_rdata` at that point.
- FIFO:
  - In order, depth `FIFO_DEPTH`.
  - `d_*` fields are driven from the head entry; `d_valid = fifo_count!=0`.
  - A pop occurs on `d_valid & d_ready`.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
- Constant outputs: `d_param=0`, `d_sink=0`. `d_size` and `d_source` echo the request.
- While `d_valid & !d_ready`, all `d_*` fields are held stable.
- `a_mask`, `a_data`, `a_corrupt` and `a_param` are ignored.

## Timing
- Reset (`reset_n` low at a rising edge):
  - `fifo_count=0`, `s1_valid=0`.
  - `d_valid=0`; all `d_*` fields are 0.
  - `mem_req=0`, `mem_addr=0`.
  - `a_ready=0` while reset is asserted and 1 in the first cycle after release.
- Latency: accept in cycle N, `d_valid` in cycle N+2. This holds when the FIFO is empty and `d_ready=1`.
- Throughput: one response per cycle with `d_ready` held high and `FIFO_DEPTH>=3`.
- Full queue: `occ==FIFO_DEPTH` forces `a_ready=0`. A pop in cycle N raises `a_ready` in cycle N+1.
- Reset mid-operation: in-flight and queued responses are discarded. `d_valid` is 0 from the cycle after the reset edge.
- `mem_req` is combinational from `a_valid & a_ready & legal_get`.

## Configuration
- `TL_INSN_RESP_PARITY_EN` defined:
  - The `mem_rparity` port exists.
  - Parity is checked when s1 captures the data. Any byte mismatch on a legal Get sets `d_corrupt=1` with `d_denied=0`; the data is still returned.
- Not defined: the port is absent. `d_corrupt` is set only on denied data responses.

## Test plan
- Single Get: Get at `BASE_ADDR+0x10`, size 2, source 1, with `mem_rdata=32'hDEADBEEF` → `mem_addr=4` in the accept cycle. Two cycles later the response is `d_opcode=1`, `d_data=DEADBEEF`, `d_source=1`, `d_size=2`, `denied=0`, `corrupt=0`.
- Back-to-back Gets: 8 Gets with `d_ready=1` → 8 consecutive `d_valid` cycles, in order, and `a_ready` never deasserts.
- Backpressure: `d_ready=0` with `a_valid=1` → 3 requests accepted, then `a_ready=0`. `d_*` stays stable. Raising `d_ready` drains 3 responses, and `a_ready` returns 1 cycle after the first pop.
- Illegal Gets: Get at `BASE_ADDR+0x1002` with size 2 (misaligned), then at `BASE_ADDR+4*MEM_WORDS` (out of range) → no `mem_req`. Both respond with opcode 1, `denied=1`, `corrupt=1`, `data=0`.
- Put and Intent: PutFullData → opcode 0, `denied=1`. Intent → opcode 2, `denied=0`.
- Parity and reset:
  - With the macro defined, `mem_rparity` bit 0 is flipped → `corrupt=1`, `denied=0`, data returned.
  - With the macro undefined, the same stimulus gives `corrupt=0`.
  - `reset_n` pulsed with 2 queued responses → `d_valid=0` next cycle, with no stale response afterwards.
